spi_reg_bank: RTL

Parametrised SPI-slave register bank. It is the next generation of the audio board's SPI register interface. It merges the SPI frame engine and the register file into one block. Over the original it adds generic register count and width, burst auto-increment access, per-register read-only mapping, and per-register write and read strobes. It sits between the rPi SPI pins and the audio, sram and mpio control logic.

---
 rtl/spi_reg_bank.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave register bank: header (r/w + address) then unbounded auto-incrementing data words.
// A write shows on regs_out 1 clk after the synchronised final rise and wr_stb 1 clk later; there is no backpressure.
module spi_reg_bank #(
    parameter int                    NUM_REGS     = 32,
    parameter int                    ADDR_BITS    = 7,
    parameter int                    DATA_BITS    = 8,
    parameter logic [NUM_REGS-1:0]   RO_MASK      = '0,
    parameter logic [DATA_BITS-1:0]  UNMAPPED_VAL = DATA_BITS'(8'h99)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            spi_cs0,
    input  logic                            spi_clk,
    input  logic                            spi_mosi,
    output logic                            spi_miso,
    output logic                            miso_oe,
    input  logic [NUM_REGS*DATA_BITS-1:0]   ro_in,
    output logic [NUM_REGS*DATA_BITS-1:0]   regs_out,
    output logic [NUM_REGS-1:0]             wr_stb,
    output logic [NUM_REGS-1:0]             rd_stb,
    output logic                            frame_active
);

    localparam int CNT_MAX = (ADDR_BITS + 1 > DATA_BITS) ? ADDR_BITS + 1 : DATA_BITS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, HEADER, DATA, LOCKOUT} state_t;

    state_t                 state;
    logic                   sclk_s1, sclk_s2, sclk_s3;
    logic                   cs_s1, cs_s2, cs_s3;
    logic                   mosi_s1, mosi_s2;
    logic [CNT_W-1:0]       bit_cnt;
    logic [ADDR_BITS-1:0]   addr;
    logic                   rw;
    logic [ADDR_BITS-1:0]   hdr_sr;
    logic [DATA_BITS-2:0]   din_sr;
    logic [DATA_BITS-1:0]   sout;
    logic [NUM_REGS-1:0]    wr_pend;

    logic                   rise, fall, cs_active, cs_fall;
    logic [ADDR_BITS:0]     hdr_word;
    logic [DATA_BITS-1:0]   din_word;
    logic [ADDR_BITS-1:0]   ld_addr;
    logic                   ld_mapped;
    logic [NUM_REGS-1:0]    ld_hot;
    logic [NUM_REGS-1:0]    addr_hot;
    logic [NUM_REGS-1:0]    wr_hot;
    logic [DATA_BITS-1:0]   rd_word;

    // cs synchronisers reset to "selected" so LOCKOUT waits for a genuine deselect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            cs_s1   <= 1'b0;
            cs_s2   <= 1'b0;
            cs_s3   <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= spi_clk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            cs_s1   <= spi_cs0;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign rise      = sclk_s2 & ~sclk_s3;
    assign fall      = ~sclk_s2 & sclk_s3;
    assign cs_active = ~cs_s2;
    assign cs_fall   = cs_s3 & ~cs_s2;

    assign hdr_word  = {hdr_sr, mosi_s2};
    assign din_word  = {din_sr, mosi_s2};
    // Address of the word about to be loaded: from the header, or the next one in a burst
    assign ld_addr   = (state == HEADER) ? hdr_word[ADDR_BITS-1:0] : addr + 1'b1;
    assign ld_mapped = int'(ld_addr) < NUM_REGS;
    assign ld_hot    = ld_mapped ? (NUM_REGS'(1) << ld_addr) : '0;
    assign addr_hot  = (int'(addr) < NUM_REGS) ? (NUM_REGS'(1) << addr) : '0;
    assign wr_hot    = addr_hot & ~RO_MASK;

    always_comb begin
        rd_word = UNMAPPED_VAL;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ld_mapped && ld_addr == ADDR_BITS'(i))
                rd_word = RO_MASK[i] ? ro_in[i*DATA_BITS +: DATA_BITS]
                                     : regs_out[i*DATA_BITS +: DATA_BITS];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LOCKOUT;
            bit_cnt      <= '0;
            addr         <= '0;
            rw           <= 1'b0;
            hdr_sr       <= '0;
            din_sr       <= '0;
            sout         <= '0;
            spi_miso     <= 1'b0;
            miso_oe      <= 1'b0;
            frame_active <= 1'b0;
            regs_out     <= '0;
            wr_pend      <= '0;
            wr_stb       <= '0;
            rd_stb       <= '0;
        end else begin
            wr_stb  <= wr_pend;
            wr_pend <= '0;
            rd_stb  <= '0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state        <= HEADER;
                        bit_cnt      <= '0;
                        miso_oe      <= 1'b1;
                        spi_miso     <= 1'b0;
                        frame_active <= 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (!cs_active)
                        state <= IDLE;
                end
                HEADER, DATA: begin
                    // Deselect outranks a coincident rise; any partial word is dropped
                    if (!cs_active) begin
                        state        <= IDLE;
                        bit_cnt      <= '0;
                        miso_oe      <= 1'b0;
                        spi_miso     <= 1'b0;
                        frame_active <= 1'b0;
                    end else if (rise) begin
                        if (state == HEADER) begin
                            hdr_sr <= hdr_word[ADDR_BITS-1:0];
                            if (bit_cnt == CNT_W'(ADDR_BITS)) begin
                                state   <= DATA;
                                rw      <= hdr_word[ADDR_BITS];
                                addr    <= ld_addr;
                                bit_cnt <= '0;
                                if (hdr_word[ADDR_BITS]) begin
                                    sout     <= rd_word;
                                    spi_miso <= rd_word[DATA_BITS-1];
                                    rd_stb   <= ld_hot;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            din_sr <= din_word[DATA_BITS-2:0];
                            if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                                bit_cnt <= '0;
                                addr    <= ld_addr;
                                if (rw) begin
                                    sout     <= rd_word;
                                    spi_miso <= rd_word[DATA_BITS-1];
                                    rd_stb   <= ld_hot;
                                end else begin
                                    for (int i = 0; i < NUM_REGS; i++)
                                        if (wr_hot[i])
                                            regs_out[i*DATA_BITS +: DATA_BITS] <= din_word;
                                    wr_pend <= wr_hot;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else if (fall && state == DATA && rw && bit_cnt != '0) begin
                        // The fall right after a word load keeps the freshly presented MSB
                        sout     <= sout << 1;
                        spi_miso <= sout[DATA_BITS-2];
                    end
                end
                default: state <= LOCKOUT;
            endcase
        end
    end

endmodule
